// File: rtl/slc3_isdu_lite.sv
// ---------------------------------------------------------------------------
// slc3_isdu_lite
//
// Instruction-sequence control unit for the SLC-3 datapath. One state per
// clock. It handles start via Run, a three-step fetch with a configurable
// memory wait, decode, and execute for ADD, AND, NOT, BR, JMP and PAUSE.
// Any other opcode runs as a NOP and goes straight back to fetch.
//
// Ports:
//   Clk, Reset          clock (rising edge), asynchronous active-low reset
//   Run, Continue       start request / resume-from-pause, level inputs
//   Opcode, IR_5, BEN   IR[15:12], IR[5], and the branch-enable flag
//   LD_*                register load strobes
//   Gate*               bus drivers, at most one high in any state
//   PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK   mux selects
//   Mem_OE, Mem_WE      memory strobes (Mem_WE is never used here)
//   State               encoded current state, for debug
//
// State encoding (fixed so the bench and debug tools can read State):
//   0 HALTED, 1 FETCH1, 2 FETCH2W, 3 FETCH2, 4 FETCH3, 5 DECODE,
//   6 ADD, 7 AND, 8 NOT, 9 BR, 10 BR_TAKE, 11 JMP, 12 PAUSE_IR1,
//   13 PAUSE_IR2. Any other value returns to HALTED.
// ---------------------------------------------------------------------------
module slc3_isdu_lite #(
   parameter int         MEM_WAIT  = 2,
   parameter logic [3:0] PAUSE_OPC = 4'b1101
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Run,
   input  logic       Continue,
   input  logic [3:0] Opcode,
   input  logic       IR_5,
   input  logic       BEN,
   output logic       LD_MAR,
   output logic       LD_MDR,
   output logic       LD_IR,
   output logic       LD_PC,
   output logic       LD_REG,
   output logic       LD_CC,
   output logic       LD_BEN,
   output logic       LD_LED,
   output logic       GatePC,
   output logic       GateMDR,
   output logic       GateALU,
   output logic       GateMARMUX,
   output logic [1:0] PCMUX,
   output logic       DRMUX,
   output logic       SR1MUX,
   output logic       SR2MUX,
   output logic       ADDR1MUX,
   output logic [1:0] ADDR2MUX,
   output logic [1:0] ALUK,
   output logic       Mem_OE,
   output logic       Mem_WE,
   output logic [4:0] State
);

   typedef enum logic [4:0] {
      HALTED    = 5'd0,
      FETCH1    = 5'd1,
      FETCH2W   = 5'd2,
      FETCH2    = 5'd3,
      FETCH3    = 5'd4,
      DECODE    = 5'd5,
      EX_ADD    = 5'd6,
      EX_AND    = 5'd7,
      EX_NOT    = 5'd8,
      EX_BR     = 5'd9,
      BR_TAKE   = 5'd10,
      EX_JMP    = 5'd11,
      PAUSE_IR1 = 5'd12,
      PAUSE_IR2 = 5'd13
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] waitCnt_q, waitCnt_d;
   logic       runPrev_q;
   logic       ledDone_q;
   logic       ir5_q;
   logic       waitDone;

   // The wait state lasts MEM_WAIT cycles, but never less than one, so a
   // zero wait still passes through FETCH2W once.
   assign waitDone = (int'(waitCnt_q) + 1 >= MEM_WAIT);

   // State and bookkeeping registers. runPrev_q resets high so that a Run
   // level held through reset is not mistaken for a fresh start request.
   // ledDone_q remembers that the previous cycle was already PAUSE_IR1,
   // which turns LD_LED into a one-cycle pulse on entry. ir5_q keeps SR2MUX
   // a pure function of registered state; IR is stable from DECODE onward.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q   <= HALTED;
         waitCnt_q <= 3'd0;
         runPrev_q <= 1'b1;
         ledDone_q <= 1'b0;
         ir5_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         waitCnt_q <= waitCnt_d;
         runPrev_q <= Run;
         ledDone_q <= (state_q == PAUSE_IR1);
         ir5_q     <= IR_5;
      end
   end

   // Next-state logic. The wait counter is only live inside FETCH2W and
   // is zero everywhere else, so every fetch starts its wait from scratch.
   always_comb begin
      state_d   = state_q;
      waitCnt_d = 3'd0;
      case (state_q)
         HALTED:    if (Run && !runPrev_q) state_d = FETCH1;
         FETCH1:    state_d = FETCH2W;
         FETCH2W: begin
            if (waitDone) state_d = FETCH2;
            else          waitCnt_d = waitCnt_q + 3'd1;
         end
         FETCH2:    state_d = FETCH3;
         FETCH3:    state_d = DECODE;
         DECODE: begin
            if (Opcode == PAUSE_OPC) begin
               state_d = PAUSE_IR1;
            end else begin
               case (Opcode)
                  4'b0001: state_d = EX_ADD;
                  4'b0101: state_d = EX_AND;
                  4'b1001: state_d = EX_NOT;
                  4'b0000: state_d = EX_BR;
                  4'b1100: state_d = EX_JMP;
                  default: state_d = FETCH1;
               endcase
            end
         end
         EX_ADD, EX_AND, EX_NOT, EX_JMP, BR_TAKE: state_d = FETCH1;
         EX_BR:     state_d = BEN ? BR_TAKE : FETCH1;
         PAUSE_IR1: if (Continue)  state_d = PAUSE_IR2;
         PAUSE_IR2: if (!Continue) state_d = FETCH1;
         default:   state_d = HALTED;
      endcase
   end

   // Moore output decode: every strobe is a function of registered state
   // only. Everything defaults to zero and each state raises what it needs.
   always_comb begin
      LD_MAR     = 1'b0;
      LD_MDR     = 1'b0;
      LD_IR      = 1'b0;
      LD_PC      = 1'b0;
      LD_REG     = 1'b0;
      LD_CC      = 1'b0;
      LD_BEN     = 1'b0;
      LD_LED     = 1'b0;
      GatePC     = 1'b0;
      GateMDR    = 1'b0;
      GateALU    = 1'b0;
      GateMARMUX = 1'b0;
      PCMUX      = 2'b00;
      DRMUX      = 1'b0;
      SR1MUX     = 1'b0;
      SR2MUX     = 1'b0;
      ADDR1MUX   = 1'b0;
      ADDR2MUX   = 2'b00;
      ALUK       = 2'b00;
      Mem_OE     = 1'b0;
      Mem_WE     = 1'b0;
      case (state_q)
         FETCH1: begin
            GatePC = 1'b1;
            LD_MAR = 1'b1;
            PCMUX  = 2'b00;
            LD_PC  = 1'b1;
         end
         FETCH2W: Mem_OE = 1'b1;
         FETCH2: begin
            Mem_OE = 1'b1;
            LD_MDR = 1'b1;
         end
         FETCH3: begin
            GateMDR = 1'b1;
            LD_IR   = 1'b1;
         end
         DECODE: LD_BEN = 1'b1;
         EX_ADD, EX_AND: begin
            SR1MUX  = 1'b1;
            SR2MUX  = ir5_q;
            ALUK    = (state_q == EX_AND) ? 2'b01 : 2'b00;
            GateALU = 1'b1;
            LD_REG  = 1'b1;
            LD_CC   = 1'b1;
         end
         EX_NOT: begin
            ALUK    = 2'b10;
            SR1MUX  = 1'b1;
            GateALU = 1'b1;
            LD_REG  = 1'b1;
            LD_CC   = 1'b1;
         end
         BR_TAKE: begin
            ADDR1MUX = 1'b0;
            ADDR2MUX = 2'b10;
            PCMUX    = 2'b10;
            LD_PC    = 1'b1;
         end
         EX_JMP: begin
            SR1MUX   = 1'b1;
            ADDR1MUX = 1'b1;
            ADDR2MUX = 2'b00;
            PCMUX    = 2'b10;
            LD_PC    = 1'b1;
         end
         PAUSE_IR1: LD_LED = !ledDone_q;
         default: ;
      endcase
   end

   assign State = state_q;

endmodule

// File: tb/tb_slc3_isdu_lite.sv
// ---------------------------------------------------------------------------
// tb_slc3_isdu_lite
//
// Self-checking bench for slc3_isdu_lite. An instruction-level model walks
// each instruction through its expected sequence of steps (fetch, decode,
// execute) and compares State plus every control output on each cycle.
// A background checker watches bus-gate exclusivity and the memory strobes.
// ---------------------------------------------------------------------------
module tb_slc3_isdu_lite;

   localparam int MEM_WAIT = 2;

   localparam logic [4:0] S_HALTED  = 5'd0;
   localparam logic [4:0] S_FETCH1  = 5'd1;
   localparam logic [4:0] S_FETCH2W = 5'd2;
   localparam logic [4:0] S_FETCH2  = 5'd3;
   localparam logic [4:0] S_FETCH3  = 5'd4;
   localparam logic [4:0] S_DECODE  = 5'd5;
   localparam logic [4:0] S_ADD     = 5'd6;
   localparam logic [4:0] S_AND     = 5'd7;
   localparam logic [4:0] S_NOT     = 5'd8;
   localparam logic [4:0] S_BR      = 5'd9;
   localparam logic [4:0] S_BRTAKE  = 5'd10;
   localparam logic [4:0] S_JMP     = 5'd11;
   localparam logic [4:0] S_PAUSE1  = 5'd12;
   localparam logic [4:0] S_PAUSE2  = 5'd13;

   typedef struct packed {
      logic       ldMar, ldMdr, ldIr, ldPc, ldReg, ldCc, ldBen, ldLed;
      logic       gatePc, gateMdr, gateAlu, gateMarmux;
      logic [1:0] pcmux;
      logic       drmux, sr1mux, sr2mux, addr1mux;
      logic [1:0] addr2mux;
      logic [1:0] aluk;
      logic       memOe, memWe;
   } ctrl_t;

   logic       Clk = 1'b0;
   logic       Reset = 1'b0;
   logic       Run = 1'b0;
   logic       Continue = 1'b0;
   logic [3:0] Opcode = 4'b0000;
   logic       IR_5 = 1'b0;
   logic       BEN = 1'b0;
   logic       LD_MAR, LD_MDR, LD_IR, LD_PC, LD_REG, LD_CC, LD_BEN, LD_LED;
   logic       GatePC, GateMDR, GateALU, GateMARMUX;
   logic [1:0] PCMUX, ADDR2MUX, ALUK;
   logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
   logic       Mem_OE, Mem_WE;
   logic [4:0] State;

   ctrl_t obs;
   int    testCount = 0;
   int    failCount = 0;
   bit    gateCheckEn = 1'b0;

   slc3_isdu_lite #(.MEM_WAIT(MEM_WAIT), .PAUSE_OPC(4'b1101)) dut (
      .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
      .Opcode(Opcode), .IR_5(IR_5), .BEN(BEN),
      .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_PC(LD_PC),
      .LD_REG(LD_REG), .LD_CC(LD_CC), .LD_BEN(LD_BEN), .LD_LED(LD_LED),
      .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU),
      .GateMARMUX(GateMARMUX), .PCMUX(PCMUX), .DRMUX(DRMUX),
      .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX),
      .ADDR2MUX(ADDR2MUX), .ALUK(ALUK), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
      .State(State)
   );

   // Free-running 100 MHz clock.
   always #5 Clk = ~Clk;

   assign obs = {LD_MAR, LD_MDR, LD_IR, LD_PC, LD_REG, LD_CC, LD_BEN, LD_LED,
                 GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, DRMUX, SR1MUX,
                 SR2MUX, ADDR1MUX, ADDR2MUX, ALUK, Mem_OE, Mem_WE};

   // Every cycle: no two bus drivers at once, and no memory writes at all.
   always @(negedge Clk) begin
      if (gateCheckEn) begin
         testCount++;
         assert (($countones({GatePC, GateMDR, GateALU, GateMARMUX}) <= 1) &&
                 (Mem_WE === 1'b0))
         else begin
            failCount++;
            $error("[TB] FAIL gate_excl: gates=%b memOe=%b memWe=%b, required at most one gate and memWe=0",
                   {GatePC, GateMDR, GateALU, GateMARMUX}, Mem_OE, Mem_WE);
         end
      end
   end

   // Advance one clock and land 1 ns past the rising edge.
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Compare State and the full control word against the expected step.
   task automatic checkOutput(input string tag, input logic [4:0] expState,
                              input ctrl_t expCtrl);
      testCount++;
      assert ((State === expState) && (obs === expCtrl))
      else begin
         failCount++;
         $error("[TB] FAIL %s: state=%0d ctrl=%h, expected state=%0d ctrl=%h",
                tag, State, obs, expState, expCtrl);
      end
   endtask

   function automatic ctrl_t fetch1Ctrl();
      ctrl_t c = '0;
      c.gatePc = 1'b1;
      c.ldMar  = 1'b1;
      c.pcmux  = 2'b00;
      c.ldPc   = 1'b1;
      return c;
   endfunction

   // Run one instruction through the model, starting from a cycle already
   // checked as FETCH1 and ending on the next FETCH1 (checked here).
   // lowN/highN are the extra cycles Continue stays low/high inside PAUSE.
   task automatic applyStimulus(input logic [3:0] opc, input logic ir5,
                                input logic ben, input int lowN,
                                input int highN);
      ctrl_t c;
      ctrl_t z;
      int    waitCycles;
      z = '0;
      Opcode = opc;
      IR_5   = ir5;
      BEN    = ben;
      waitCycles = (MEM_WAIT == 0) ? 1 : MEM_WAIT;
      for (int w = 0; w < waitCycles; w++) begin
         Continue = 1'($urandom_range(0, 1));
         Run      = 1'($urandom_range(0, 1));
         tick();
         c = z; c.memOe = 1'b1;
         checkOutput("fetch2w", S_FETCH2W, c);
      end
      tick();
      c = z; c.memOe = 1'b1; c.ldMdr = 1'b1;
      checkOutput("fetch2", S_FETCH2, c);
      tick();
      c = z; c.gateMdr = 1'b1; c.ldIr = 1'b1;
      checkOutput("fetch3", S_FETCH3, c);
      Continue = 1'b0;
      Run      = 1'b0;
      tick();
      c = z; c.ldBen = 1'b1;
      checkOutput("decode", S_DECODE, c);
      if (opc == 4'b1101) begin
         tick();
         c = z; c.ldLed = 1'b1;
         checkOutput("pause_led", S_PAUSE1, c);
         for (int i = 0; i < lowN; i++) begin
            tick();
            checkOutput("pause1_hold", S_PAUSE1, z);
         end
         Continue = 1'b1;
         tick();
         checkOutput("pause2_enter", S_PAUSE2, z);
         for (int i = 0; i < highN; i++) begin
            tick();
            checkOutput("pause2_hold", S_PAUSE2, z);
         end
         Continue = 1'b0;
      end else begin
         case (opc)
            4'b0001, 4'b0101: begin
               tick();
               c = z; c.sr1mux = 1'b1; c.sr2mux = ir5; c.gateAlu = 1'b1;
               c.ldReg = 1'b1; c.ldCc = 1'b1;
               c.aluk = (opc == 4'b0101) ? 2'b01 : 2'b00;
               if (opc == 4'b0101) checkOutput("and", S_AND, c);
               else                checkOutput("add", S_ADD, c);
            end
            4'b1001: begin
               tick();
               c = z; c.aluk = 2'b10; c.sr1mux = 1'b1; c.gateAlu = 1'b1;
               c.ldReg = 1'b1; c.ldCc = 1'b1;
               checkOutput("not", S_NOT, c);
            end
            4'b0000: begin
               tick();
               checkOutput("br", S_BR, z);
               if (ben) begin
                  tick();
                  c = z; c.addr2mux = 2'b10; c.pcmux = 2'b10; c.ldPc = 1'b1;
                  checkOutput("br_take", S_BRTAKE, c);
               end
            end
            4'b1100: begin
               tick();
               c = z; c.sr1mux = 1'b1; c.addr1mux = 1'b1; c.pcmux = 2'b10;
               c.ldPc = 1'b1;
               checkOutput("jmp", S_JMP, c);
            end
            default: ;
         endcase
      end
      tick();
      checkOutput("fetch1", S_FETCH1, fetch1Ctrl());
   endtask

   // Directed steps first, then a stretch of random instructions.
   initial begin
      ctrl_t z;
      z = '0;

      tick();
      tick();
      checkOutput("reset_halted", S_HALTED, z);
      gateCheckEn = 1'b1;

      Reset = 1'b1;
      tick();
      checkOutput("idle_halted", S_HALTED, z);
      tick();
      checkOutput("idle_halted2", S_HALTED, z);

      Run = 1'b1;
      tick();
      checkOutput("run_start", S_FETCH1, fetch1Ctrl());
      Run = 1'b0;

      applyStimulus(4'b0001, 1'b1, 1'b0, 0, 0);
      applyStimulus(4'b0101, 1'b0, 1'b1, 0, 0);
      applyStimulus(4'b0001, 1'b0, 1'b0, 0, 0);
      applyStimulus(4'b1001, 1'b1, 1'b0, 0, 0);
      applyStimulus(4'b0000, 1'b0, 1'b0, 0, 0);
      applyStimulus(4'b0000, 1'b1, 1'b1, 0, 0);
      applyStimulus(4'b1100, 1'b0, 1'b0, 0, 0);
      applyStimulus(4'b1111, 1'b1, 1'b1, 0, 0);
      applyStimulus(4'b1101, 1'b0, 1'b0, 4, 4);
      applyStimulus(4'b1101, 1'b0, 1'b0, 2, 19);

      // Reset in the second FETCH2W cycle with Run held high throughout.
      Opcode = 4'b0001;
      tick();
      checkOutput("rst_fetch2w_a", S_FETCH2W, '{memOe: 1'b1, default: '0});
      Run = 1'b1;
      tick();
      checkOutput("rst_fetch2w_b", S_FETCH2W, '{memOe: 1'b1, default: '0});
      Reset = 1'b0;
      #1;
      checkOutput("reset_async", S_HALTED, z);
      tick();
      checkOutput("reset_held", S_HALTED, z);
      Reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("run_level_no_start", S_HALTED, z);
      end
      Run = 1'b0;
      tick();
      checkOutput("run_low", S_HALTED, z);
      Run = 1'b1;
      tick();
      checkOutput("run_restart", S_FETCH1, fetch1Ctrl());
      Run = 1'b0;
      applyStimulus(4'b0101, 1'b1, 1'b0, 0, 0);

      for (int n = 0; n < 200; n++) begin
         applyStimulus(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 3)));
      end

      gateCheckEn = 1'b0;
      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
